// File: rtl/logic_accum.sv
// rtl/logic_accum.sv - frame-based bitwise accumulator with valid/ready handshake on both sides
//
// Purpose:
//   Folds the operand beats of a frame with one bitwise operation (AND, OR,
//   XOR or NAND) chosen on the first beat, and presents the frame result
//   together with a saturating beat count once the beat marked last is taken.
//   The result register is a single-entry skid-free output stage: a new result
//   may load in the same cycle the previous one is delivered.
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RST_X    in   asynchronous active-low reset
//   I_VALID  in   operand beat presented
//   I_READY  out  beat accepted this cycle when I_VALID is also high
//   I_DATA   in   operand [WIDTH]
//   I_OP     in   00 AND, 01 OR, 10 XOR, 11 NAND (sampled on first beat only)
//   I_LAST   in   beat closes the current frame
//   O_VALID  out  result register holds an undelivered result
//   O_READY  in   consumer takes the result this cycle
//   O_DATA   out  frame result [WIDTH]
//   O_COUNT  out  beats in the frame, saturating [CNTW]

module logic_accum #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I_DATA,
  input  logic [1:0]       I_OP,
  input  logic             I_LAST,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O_DATA,
  output logic [CNTW-1:0]  O_COUNT
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [CNTW-1:0]  cnt_q,     cnt_d;
  logic [1:0]       op_q,      op_d;
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q,  o_data_d;
  logic [CNTW-1:0]  o_count_q, o_count_d;

  logic             in_ready;
  logic             accept;
  logic             deliver;
  logic             first_beat;
  logic [1:0]       op_eff;
  logic [WIDTH-1:0] acc_next;
  logic [CNTW-1:0]  cnt_next;

  // NAND folds as AND; the inversion is applied once, to the final result.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // The input side may take a beat whenever the output register is free or
  // is being emptied this same cycle.
  assign in_ready = !o_valid_q || O_READY;
  assign accept   = I_VALID && in_ready;
  assign deliver  = o_valid_q && O_READY;

  always_comb begin
    first_beat = (state_q == ST_IDLE);
    op_eff     = first_beat ? I_OP : op_q;
    acc_next   = first_beat ? I_DATA : apply_op(acc_q, I_DATA, op_q);
    cnt_next   = first_beat ? CNT_ONE : sat_inc(cnt_q);

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_count_d = o_count_q;

    if (deliver) begin
      o_valid_d = 1'b0;
    end

    if (accept) begin
      if (I_LAST) begin
        // Closing beat: a load here overrides the clear from a same-cycle
        // delivery, which is what gives one frame per cycle back-to-back.
        o_valid_d = 1'b1;
        o_data_d  = (op_eff == OP_NAND) ? ~acc_next : acc_next;
        o_count_d = cnt_next;
        state_d   = ST_IDLE;
        acc_d     = '0;
        cnt_d     = '0;
        op_d      = OP_AND;
      end else begin
        acc_d   = acc_next;
        cnt_d   = cnt_next;
        op_d    = op_eff;
        state_d = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= OP_AND;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_count_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_count_q <= o_count_d;
    end
  end

  assign I_READY = in_ready;
  assign O_VALID = o_valid_q;
  assign O_DATA  = o_data_q;
  assign O_COUNT = o_count_q;

endmodule

// File: tb/tb_logic_accum.sv
// tb/tb_logic_accum.sv - directed table-driven bench for logic_accum
module tb_logic_accum;

  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst_x;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_data;
  logic [1:0]       i_op;
  logic             i_last;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic [CNTW-1:0]  o_count;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  logic_accum #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK     (clk),
    .RST_X   (rst_x),
    .I_VALID (i_valid),
    .I_READY (i_ready),
    .I_DATA  (i_data),
    .I_OP    (i_op),
    .I_LAST  (i_last),
    .O_VALID (o_valid),
    .O_READY (o_ready),
    .O_DATA  (o_data),
    .O_COUNT (o_count)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [1:0] op;
    logic       last;
    logic       ordy;
    logic       e_irdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic [3:0] e_oc;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [1:0] op,
                              input logic last, input logic ordy, input logic e_irdy,
                              input logic e_ov, input logic [7:0] e_od, input logic [3:0] e_oc);
    vec_t r;
    r.v = v; r.d = d; r.op = op; r.last = last; r.ordy = ordy;
    r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_od = e_od; r.e_oc = e_oc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] op,
                       input logic last, input logic ordy);
    i_valid = v; i_data = d; i_op = op; i_last = last; o_ready = ordy;
  endtask

  initial begin
    // inputs: v, data, op, last, o_ready | expected: i_ready, o_valid, o_data, o_count
    // AND frame F0,3C,FF -> 30, count 3, valid one cycle
    vecs[0]  = mk(1, 8'hF0, 2'b00, 0, 1,  1, 0, 8'h00, 4'h0);
    vecs[1]  = mk(1, 8'h3C, 2'b00, 0, 1,  1, 0, 8'h00, 4'h0);
    vecs[2]  = mk(1, 8'hFF, 2'b00, 1, 1,  1, 0, 8'h00, 4'h0);
    vecs[3]  = mk(0, 8'h00, 2'b00, 0, 1,  1, 1, 8'h30, 4'h3);
    vecs[4]  = mk(0, 8'h00, 2'b00, 0, 1,  1, 0, 8'h00, 4'h0);
    // XOR single A5, then NAND 0F,F3 (later op field ignored) -> A5/1 then FC/2
    vecs[5]  = mk(1, 8'hA5, 2'b10, 1, 1,  1, 0, 8'h00, 4'h0);
    vecs[6]  = mk(1, 8'h0F, 2'b11, 0, 1,  1, 1, 8'hA5, 4'h1);
    vecs[7]  = mk(1, 8'hF3, 2'b00, 1, 1,  1, 0, 8'h00, 4'h0);
    vecs[8]  = mk(0, 8'h00, 2'b00, 0, 1,  1, 1, 8'hFC, 4'h2);
    vecs[9]  = mk(0, 8'h00, 2'b00, 0, 1,  1, 0, 8'h00, 4'h0);
    // OR 01,02 held for 3 cycles, AND frame 0F,3C stalls until consumer ready
    vecs[10] = mk(1, 8'h01, 2'b01, 0, 0,  1, 0, 8'h00, 4'h0);
    vecs[11] = mk(1, 8'h02, 2'b01, 1, 0,  1, 0, 8'h00, 4'h0);
    vecs[12] = mk(1, 8'h0F, 2'b00, 0, 0,  0, 1, 8'h03, 4'h2);
    vecs[13] = mk(1, 8'h0F, 2'b00, 0, 0,  0, 1, 8'h03, 4'h2);
    vecs[14] = mk(1, 8'h0F, 2'b00, 0, 0,  0, 1, 8'h03, 4'h2);
    vecs[15] = mk(1, 8'h0F, 2'b00, 0, 1,  1, 1, 8'h03, 4'h2);
    vecs[16] = mk(1, 8'h3C, 2'b01, 1, 1,  1, 0, 8'h00, 4'h0);
    vecs[17] = mk(0, 8'h00, 2'b00, 0, 1,  1, 1, 8'h0C, 4'h2);
    vecs[18] = mk(0, 8'h00, 2'b00, 0, 1,  1, 0, 8'h00, 4'h0);
    // back-to-back single-beat frames 11,22,33
    vecs[19] = mk(1, 8'h11, 2'b00, 1, 1,  1, 0, 8'h00, 4'h0);
    vecs[20] = mk(1, 8'h22, 2'b01, 1, 1,  1, 1, 8'h11, 4'h1);
    vecs[21] = mk(1, 8'h33, 2'b10, 1, 1,  1, 1, 8'h22, 4'h1);
    vecs[22] = mk(0, 8'h00, 2'b00, 0, 1,  1, 1, 8'h33, 4'h1);
    vecs[23] = mk(0, 8'h00, 2'b00, 0, 1,  1, 0, 8'h00, 4'h0);
    // NAND single beat 5A -> A5, held one cycle
    vecs[24] = mk(1, 8'h5A, 2'b11, 1, 0,  1, 0, 8'h00, 4'h0);
    vecs[25] = mk(0, 8'h00, 2'b00, 0, 0,  0, 1, 8'hA5, 4'h1);
    vecs[26] = mk(0, 8'h00, 2'b00, 0, 1,  1, 1, 8'hA5, 4'h1);
    vecs[27] = mk(0, 8'h00, 2'b00, 0, 1,  1, 0, 8'h00, 4'h0);

    rst_x = 1'b0;
    drive(0, 8'h00, 2'b00, 0, 0);

    // reset state, and no acceptance while reset is held across an edge
    @(negedge clk);
    drive(1, 8'h99, 2'b00, 1, 0);
    #1;
    check("reset o_valid", o_valid, 0);
    check("reset o_data", o_data, 0);
    check("reset o_count", o_count, 0);
    check("reset i_ready", i_ready, 1);
    @(negedge clk);
    rst_x = 1'b1;
    drive(0, 8'h00, 2'b00, 0, 0);
    #1;
    check("no accept in reset", o_valid, 0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].d, vecs[i].op, vecs[i].last, vecs[i].ordy);
      #1;
      check($sformatf("row%0d i_ready", i), i_ready, vecs[i].e_irdy);
      check($sformatf("row%0d o_valid", i), o_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        check($sformatf("row%0d o_data", i), o_data, vecs[i].e_od);
        check($sformatf("row%0d o_count", i), o_count, vecs[i].e_oc);
      end
    end

    // saturation: 20 OR beats of 01
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1, 8'h01, 2'b01, (i == 19), 1);
      #1;
      check($sformatf("sat beat%0d i_ready", i), i_ready, 1);
      check($sformatf("sat beat%0d o_valid", i), o_valid, 0);
    end
    @(negedge clk);
    drive(0, 8'h00, 2'b00, 0, 1);
    #1;
    check("sat o_valid", o_valid, 1);
    check("sat o_data", o_data, 8'h01);
    check("sat o_count", o_count, 4'hF);

    // asynchronous reset clears a pending result without a clock edge
    @(negedge clk);
    drive(1, 8'h77, 2'b00, 1, 0);
    @(negedge clk);
    drive(0, 8'h00, 2'b00, 0, 0);
    #1;
    check("pend o_valid", o_valid, 1);
    check("pend o_data", o_data, 8'h77);
    #1;
    rst_x = 1'b0;
    #1;
    check("async rst o_valid", o_valid, 0);
    check("async rst o_data", o_data, 0);
    check("async rst o_count", o_count, 0);
    check("async rst i_ready", i_ready, 1);
    @(negedge clk);
    rst_x = 1'b1;

    // reset mid-frame discards the partial AND frame F0,3C
    @(negedge clk);
    drive(1, 8'hF0, 2'b00, 0, 1);
    @(negedge clk);
    drive(1, 8'h3C, 2'b00, 0, 1);
    @(negedge clk);
    drive(1, 8'h00, 2'b00, 1, 1);
    #2;
    rst_x = 1'b0;
    #1;
    check("midframe rst o_valid", o_valid, 0);
    check("midframe rst i_ready", i_ready, 1);
    @(negedge clk);
    rst_x = 1'b1;
    drive(0, 8'h00, 2'b00, 0, 1);
    #1;
    check("midframe no accept", o_valid, 0);
    @(negedge clk);
    drive(1, 8'h0F, 2'b01, 1, 1);
    @(negedge clk);
    drive(0, 8'h00, 2'b00, 0, 1);
    #1;
    check("post rst o_valid", o_valid, 1);
    check("post rst o_data", o_data, 8'h0F);
    check("post rst o_count", o_count, 4'h1);
    @(negedge clk);
    #1;
    check("post rst delivered", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
